sync_fifo_level: RTL
====================

# sync_fifo_level

Single-clock, parametrised FIFO and the single-clock counterpart of the team's FIFO family. It adds programmable almost-full/almost-empty thresholds, an exact fill level, overflow/underflow reporting, non-power-of-two depth and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producer/consumer pipelines, e.g. in front of CDC stages or as an elastic buffer.

## Interface
- DATA_WIDTH, 32, width of each entry
- DEPTH, 16, number of entries; any value ≥ 2, power of two not required
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency, 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, wr_almost_full asserts when level ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, rd_almost_empty asserts when level ≤ AE_THRESH; legal range 0..DEPTH-1
- LW (localparam), $clog2(DEPTH+1), width of level
- Illegal DEPTH, AF_THRESH or AE_THRESH is an elaboration-time error.

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- wr_full  out  1  level == DEPTH
- wr_almost_full  out  1  level ≥ AF_THRESH
- overflow  out  1  one-cycle pulse: wr_en while wr_full
- rd_en  in  1  read request (acknowledge of the head word in FWFT mode)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word this cycle
- rd_empty  out  1  level == 0
- rd_almost_empty  out  1  level ≤ AE_THRESH
- underflow  out  1  one-cycle pulse: rd_en while rd_empty
- level  out  LW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH × DATA_WIDTH array. Storage is not reset.
- Pointers: wr_ptr and rd_ptr, range 0..DEPTH-1. Each wraps explicitly from DEPTH-1 to 0; no modulo-2^n assumption.
- Count register level:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both are accepted or neither is.
- Write accepted: wr_en && !wr_full. Stores wr_data at wr_ptr and advances wr_ptr.
- Read accepted: rd_en && !rd_empty. Advances rd_ptr.
- Flags are decoded only from the level register (glitch-free, no input-to-flag combinational path).
- Full, simultaneous wr_en+rd_en: read accepted, write rejected, overflow pulses. level becomes DEPTH-1.
- Empty, simultaneous wr_en+rd_en: write accepted, read rejected, underflow pulses. level becomes 1.
- FWFT=0:
  - On an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1:
  - rd_data = mem[rd_ptr] continuously.
  - rd_valid = !rd_empty.
  - rd_en pops the head word, and the next word is presented after the edge.
- Rejected requests never change pointers, level or storage.

## Timing
- Reset values (asynchronous, immediate on rst):
  - wr_ptr = rd_ptr = level = 0
  - wr_full = 0, wr_almost_full = (AF_THRESH == 0 ? n/a : 0), rd_empty = 1, rd_almost_empty = 1
  - rd_valid = 0, rd_data = 0 (FWFT=0; in FWFT=1 rd_data is don't-care while rd_valid = 0)
  - overflow = underflow = 0
- Reset mid-operation discards all contents. After release, the first posedge accepts requests normally.
- Write-to-read visibility: a write at edge N → rd_empty = 0 and level updated after edge N.
  - FWFT=1: word on rd_data in cycle N+1.
  - FWFT=0: a read accepted at N+1 → rd_valid/rd_data after edge N+1.
- Throughput: one write and one read per cycle sustained, including at DEPTH-1/1 boundaries.
- overflow/underflow are registered, asserting the cycle after the offending request for exactly one cycle per offending cycle.
- Flag and level updates are all 1 cycle after the causing edge, with no combinational path from wr_en/rd_en.

## Test plan
- Reset/fill, DEPTH=5, AF=4, AE=1, FWFT=0. Write 0xA0..0xA4 on consecutive cycles:
  - level steps 1..5.
  - rd_almost_empty drops when level=2.
  - wr_almost_full rises at level=4.
  - wr_full rises at level=5.
  - A 6th write pulses overflow, and level stays 5.
- Drain the same FIFO with 6 reads:
  - rd_data = 0xA0..0xA4 each one cycle after rd_en, with rd_valid high.
  - The 6th read pulses underflow; rd_empty = 1, level = 0.
- Wrap-around, DEPTH=5: 12 cycles of simultaneous write/read at level=2 (data 0x10..0x1B):
  - level constant at 2.
  - Output order is exact through multiple pointer wraps past index 4.
- Boundary simultaneity:
  - At full, wr_en+rd_en → level 4, overflow = 1, oldest word read.
  - At empty, wr_en+rd_en → level 1, underflow = 1.
- FWFT=1:
  - Write 0x55 → rd_valid = 1, rd_data = 0x55 the next cycle without rd_en.
  - Pop → rd_valid = 0.
- Async reset: assert rst mid-cycle at level=3 → immediately level = 0, rd_empty = 1, rd_valid = 0. The next write/read after release returns the new data only.

Source files
------------

// File: rtl/sync_fifo_level.sv
// sync_fifo_level: single-clock FIFO with exact fill level, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses, arbitrary
// (non power-of-two) depth and a selectable registered or first-word-fall-through
// read port. All flags decode from the registered level, so no request input
// has a combinational path to any status output.
module sync_fifo_level #(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 16,
   parameter int  FWFT       = 0,
   parameter int  AF_THRESH  = DEPTH - 2,
   parameter int  AE_THRESH  = 2,
   localparam int LW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   output logic                  overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic                  underflow,
   output logic [LW-1:0]         level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
   localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

   // Parameter legality is checked while elaborating, never at run time.
   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_level: DEPTH must be at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_level: AF_THRESH must lie in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_level: AE_THRESH must lie in 0..DEPTH-1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo_level: FWFT must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Pointers wrap explicitly at DEPTH-1 so any depth works.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // Status flags come straight from the level register.
   assign wr_full         = (level == LVL_FULL);
   assign wr_almost_full  = (level >= LVL_AF);
   assign rd_empty        = (level == '0);
   assign rd_almost_empty = (level <= LVL_AE);

   // At full a simultaneous read still goes through and the write is refused;
   // at empty the write goes through and the read is refused.
   assign wr_acc = wr_en && !wr_full;
   assign rd_acc = rd_en && !rd_empty;

   // Pointer, occupancy and error-pulse state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_en && wr_full;
         underflow <= rd_en && rd_empty;
         if (wr_acc) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en acts as the pop acknowledge.
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !rd_empty;
   end else begin : g_registered
      // Registered read: data and valid appear one edge after an accepted read.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
               rd_data <= mem[rd_ptr];
            end
         end
      end
   end

endmodule
